// File: rtl/wb_writeback_queue_if.sv
// Bundle for the write-back queue: producer handshakes (MEM, ALU), the
// register-file write port, forwarding lookups and occupancy.
// master = EX/MEM/decode side, slave = the queue itself.
interface wb_writeback_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              w_enable;
    logic [ADDR_W-1:0] wd_addr;
    logic [DATA_W-1:0] wd_data;

    logic [ADDR_W-1:0] fw_rs_addr;
    logic [ADDR_W-1:0] fw_rt_addr;
    logic              fw_rs_hit;
    logic              fw_rt_hit;
    logic [DATA_W-1:0] fw_rs_data;
    logic [DATA_W-1:0] fw_rt_data;

    logic [CNT_W-1:0]  pending_cnt;

    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_addr, alu_data,
        output fw_rs_addr, fw_rt_addr,
        input  mem_ready, alu_ready,
        input  w_enable, wd_addr, wd_data,
        input  fw_rs_hit, fw_rt_hit, fw_rs_data, fw_rt_data,
        input  pending_cnt
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_addr, alu_data,
        input  fw_rs_addr, fw_rt_addr,
        output mem_ready, alu_ready,
        output w_enable, wd_addr, wd_data,
        output fw_rs_hit, fw_rt_hit, fw_rs_data, fw_rt_data,
        output pending_cnt
    );
endinterface

// File: rtl/wb_writeback_queue.sv
// In-order write-back queue in front of the register file write port.
// MEM has fixed priority over ALU; results for $zero are swallowed.
// The head is written (and popped) every cycle the queue is non-empty.
// Optional macro WB_FORWARD_EN builds the youngest-match forwarding lookup;
// without it the forwarding outputs are tied to 0.
module wb_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input logic               clk,
    input logic               rst_n,
    wb_writeback_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic              not_full, mem_fire, alu_fire, push, pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;

    assign not_full      = count < CNT_W'(DEPTH);
    assign bus.mem_ready = not_full;
    assign bus.alu_ready = not_full && !bus.mem_valid;

    assign mem_fire  = bus.mem_valid && not_full;
    assign alu_fire  = bus.alu_valid && bus.alu_ready;
    assign push_addr = mem_fire ? bus.mem_addr : bus.alu_addr;
    assign push_data = mem_fire ? bus.mem_data : bus.alu_data;
    // A completed handshake to register 0 is consumed without enqueueing.
    assign push      = (mem_fire || alu_fire) && (push_addr != '0);
    assign pop       = count != '0;

    // Pointer and occupancy bookkeeping; reset discards all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Entry storage needs no reset: validity comes from count/rd_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    assign bus.w_enable    = pop;
    assign bus.wd_addr     = pop ? addr_q[rd_ptr] : '0;
    assign bus.wd_data     = pop ? data_q[rd_ptr] : '0;
    assign bus.pending_cnt = count;

`ifdef WB_FORWARD_EN
    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        bus.fw_rs_hit  = 1'b0;
        bus.fw_rs_data = '0;
        bus.fw_rt_hit  = 1'b0;
        bus.fw_rt_data = '0;
        idx            = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if (bus.fw_rs_addr != '0 && addr_q[idx] == bus.fw_rs_addr) begin
                    bus.fw_rs_hit  = 1'b1;
                    bus.fw_rs_data = data_q[idx];
                end
                if (bus.fw_rt_addr != '0 && addr_q[idx] == bus.fw_rt_addr) begin
                    bus.fw_rt_hit  = 1'b1;
                    bus.fw_rt_data = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_fw;
    assign unused_fw      = ^{bus.fw_rs_addr, bus.fw_rt_addr};
    assign bus.fw_rs_hit  = 1'b0;
    assign bus.fw_rt_hit  = 1'b0;
    assign bus.fw_rs_data = '0;
    assign bus.fw_rt_data = '0;
`endif
endmodule

// File: doc/wb_writeback_queue.md
# wb_writeback_queue

Write-back queue feeding the register file write port: accepts results from the ALU and MEM stages over valid/ready handshakes, buffers them in order in a small FIFO, and issues at most one register write per cycle on `w_enable`/`wd_addr`/`wd_data`. It sits between the EX/MEM stages and the register file, which samples the write port on the falling edge of `clk`. An optional forwarding lookup reports pending (not yet written) values for the two decode-stage source registers.

## Interface
- `DATA_W`, 32, result/register data width
- `ADDR_W`, 5, register address width
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `clk` in 1: single clock; all state updates on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `mem_valid` in 1: MEM result valid
- `mem_ready` out 1: queue accepts MEM result this cycle
- `mem_addr` in ADDR_W: MEM destination register
- `mem_data` in DATA_W: MEM result
- `alu_valid`, `alu_ready`, `alu_addr`, `alu_data`: same roles for the ALU source
- `w_enable` out 1: register write request this cycle
- `wd_addr` out ADDR_W: write address
- `wd_data` out DATA_W: write data
- `fw_rs_addr`, `fw_rt_addr` in ADDR_W: lookup addresses
- `fw_rs_hit`, `fw_rt_hit` out 1: a pending entry targets the address
- `fw_rs_data`, `fw_rt_data` out DATA_W: youngest matching pending value
- `pending_cnt` out $clog2(DEPTH)+1: current FIFO occupancy

## Operation
- Circular FIFO: `wr_ptr`, `rd_ptr` (log2 DEPTH bits, natural wrap) and `count` (0..DEPTH).
- Arbitration: at most one push per cycle. MEM has fixed priority.
  - `mem_ready` = `count < DEPTH`.
  - `alu_ready` = `count < DEPTH` && !`mem_valid`.
- A handshake completes when valid && ready at the rising edge.
- Completed handshakes with address 0 are consumed and not enqueued: $zero is never written.
- Write port:
  - `w_enable` = (`count` != 0).
  - `wd_addr` and `wd_data` = head entry; both are 0 when the FIFO is empty.
  - The head is popped at every rising edge where `count` != 0.
- Push and pop in the same edge: `count` is unchanged. No push is possible while full, even though a pop occurs that edge.
- Forwarding:
  - Compare each lookup address against all valid entries; address 0 never hits.
  - On multiple matches, return the entry closest to the tail (youngest).
  - Purely combinational from the registered state.
- `pending_cnt` = `count`.

## Timing
- Reset (asynchronous, immediate): `count`, `wr_ptr`, `rd_ptr` = 0; all buffered entries are discarded.
- Reset values of outputs: `w_enable` = 0, `wd_addr` = 0, `wd_data` = 0, `pending_cnt` = 0, `mem_ready` = 1, `alu_ready` = !`mem_valid`, hits = 0, forwarding data = 0.
- Latency: a result accepted at edge N drives `w_enable` during cycle N→N+1 when the FIFO was empty. The register file commits it on the falling edge inside that cycle.
- Throughput: one write per cycle sustained; occupancy stays 1 under a continuous single-source stream.
- Order: writes issue in acceptance order. A later write to the same register always lands after an earlier one.
- An entry stays visible to forwarding until the edge that pops it. After that edge the register file already holds the value.

## Configuration
- `WB_FORWARD_EN` defined:
  - Forwarding comparators and muxes are built.
  - Hits and data are as described under Operation.
- `WB_FORWARD_EN` undefined:
  - Ports remain.
  - `fw_rs_hit`, `fw_rt_hit`, `fw_rs_data`, `fw_rt_data` are tied to 0.
  - No comparator logic is built.

## Test plan
- Reset with `rst_n`=0 mid-stream holding 3 entries → `w_enable`=0, `pending_cnt`=0 immediately; after release, no stale write is issued.
- Single ALU push (addr 7, data 0x0000_00AB) into empty FIFO at edge N → `w_enable`=1, `wd_addr`=7, `wd_data`=0xAB for exactly one cycle; register 7 reads 0xAB afterwards.
- Both sources valid (MEM addr 3 / 0x11, ALU addr 4 / 0x22) → `alu_ready`=0 that cycle; MEM accepted first; writes issue as 3 then 4 on consecutive cycles.
- Stall the drain view by pushing MEM every cycle for DEPTH+2 cycles while also pushing ALU → occupancy never exceeds DEPTH; `mem_ready`=0 only when `count`=4; no entry is lost or duplicated.
- Push to addr 0 with data 0xFFFF_FFFF → handshake completes, `pending_cnt` stays 0, `w_enable` stays 0.
- `WB_FORWARD_EN` on: enqueue addr 5 / 0x10 then addr 5 / 0x20 with `fw_rs_addr`=5 → `fw_rs_hit`=1, `fw_rs_data`=0x20; after both pops `fw_rs_hit`=0. With the macro off: `fw_rs_hit`=0 throughout.
